reg_bank_8x16bits: RTL and testbench

REG_BANK_8X16BITS -- requirements
Module: reg_bank_8x16bits

---
 rtl/reg_bank_8x16bits_pkg.sv | 17 +
 rtl/reg_bank_8x16bits_reg16.sv | 24 ++
 rtl/reg_bank_8x16bits.sv | 104 ++++++++++
 tb/tb_reg_bank_8x16bits.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/reg_bank_8x16bits_pkg.sv
// Shared constants and types for the 8x16 register bank, its read mux
// and the CPU datapath.
package reg_bank_8x16bits_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } state_e;

endpackage

// File: rtl/reg_bank_8x16bits_reg16.sv
// 16-bit register with synchronous reset and load enable.
module reg_16bits
    import reg_bank_8x16bits_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  en_i,
    input  data_t d_i,
    output data_t q_o
);

    data_t q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/reg_bank_8x16bits.sv
// Eight 16-bit registers with a single write port and a
// one-register-per-cycle clear sequence.
module reg_bank_8x16bits
    import reg_bank_8x16bits_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        WE,
    input  logic [2:0]  WA,
    input  logic [15:0] WD,
    input  logic        CLR,
    output logic [15:0] OUT0,
    output logic [15:0] OUT1,
    output logic [15:0] OUT2,
    output logic [15:0] OUT3,
    output logic [15:0] OUT4,
    output logic [15:0] OUT5,
    output logic [15:0] OUT6,
    output logic [15:0] OUT7,
    output logic        WACK,
    output logic        BUSY
);

    state_e              state_q, state_d;
    addr_t               cnt_q, cnt_d;
    logic                wack_q, wack_d;
    logic [NUM_REGS-1:0] ld;
    data_t               ld_data;
    data_t               q [NUM_REGS];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wack_q  <= wack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (CLR) begin
                    state_d = CLEARING;
                    cnt_d   = '0;
                end
            end
            CLEARING: begin
                cnt_d = cnt_q + addr_t'(1);
                if (cnt_q == addr_t'(NUM_REGS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // CLR beats WE in IDLE; during CLEARING both requests are ignored.
    always_comb begin
        ld      = '0;
        ld_data = WD;
        wack_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!CLR && WE) begin
                    ld[WA] = 1'b1;
                    wack_d = 1'b1;
                end
            end
            CLEARING: begin
                ld[cnt_q] = 1'b1;
                ld_data   = '0;
            end
            default: ld = '0;
        endcase
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        reg_16bits u_reg (
            .clk_i (CLK),
            .rst_i (RST),
            .en_i  (ld[i]),
            .d_i   (ld_data),
            .q_o   (q[i])
        );
    end

    assign OUT0 = q[0];
    assign OUT1 = q[1];
    assign OUT2 = q[2];
    assign OUT3 = q[3];
    assign OUT4 = q[4];
    assign OUT5 = q[5];
    assign OUT6 = q[6];
    assign OUT7 = q[7];
    assign WACK = wack_q;
    assign BUSY = (state_q == CLEARING);

endmodule

// File: tb/tb_reg_bank_8x16bits.sv
// Directed and randomized checks for reg_bank_8x16bits.
module tb_reg_bank_8x16bits;

    logic        CLK = 1'b0;
    logic        RST, WE, CLR;
    logic [2:0]  WA;
    logic [15:0] WD;
    logic [15:0] OUT0, OUT1, OUT2, OUT3, OUT4, OUT5, OUT6, OUT7;
    logic        WACK, BUSY;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_reg [8];
    logic        m_busy;
    logic [2:0]  m_cnt;
    logic        m_wack;
    logic [15:0] outs [8];

    reg_bank_8x16bits dut (
        .CLK (CLK), .RST (RST), .WE (WE), .WA (WA), .WD (WD), .CLR (CLR),
        .OUT0 (OUT0), .OUT1 (OUT1), .OUT2 (OUT2), .OUT3 (OUT3),
        .OUT4 (OUT4), .OUT5 (OUT5), .OUT6 (OUT6), .OUT7 (OUT7),
        .WACK (WACK), .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        outs[0] = OUT0; outs[1] = OUT1; outs[2] = OUT2; outs[3] = OUT3;
        outs[4] = OUT4; outs[5] = OUT5; outs[6] = OUT6; outs[7] = OUT7;
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural model advanced with the inputs present at the edge.
    task automatic tick();
        if (RST) begin
            for (int i = 0; i < 8; i++) m_reg[i] = '0;
            m_busy = 0; m_cnt = 0; m_wack = 0;
        end else if (!m_busy) begin
            m_wack = 0;
            if (CLR) begin
                m_busy = 1; m_cnt = 0;
            end else if (WE) begin
                m_reg[WA] = WD; m_wack = 1;
            end
        end else begin
            m_reg[m_cnt] = '0;
            m_wack = 0;
            if (m_cnt == 3'd7) m_busy = 0;
            m_cnt = m_cnt + 3'd1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all(input string tag);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_out%0d", tag, i), outs[i], m_reg[i]);
        chk({tag, "_wack"}, 16'(WACK), 16'(m_wack));
        chk({tag, "_busy"}, 16'(BUSY), 16'(m_busy));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_reg[i] = 'x;
        m_busy = 0; m_cnt = 0; m_wack = 0;
        RST = 1; WE = 0; CLR = 0; WA = 0; WD = 0;

        // Reset held two cycles.
        tick(); tick();
        for (int i = 0; i < 8; i++) chk($sformatf("rst_out%0d", i), outs[i], 16'h0000);
        chk("rst_wack", 16'(WACK), 16'h0);
        chk("rst_busy", 16'(BUSY), 16'h0);

        // Write sweep directly after reset release.
        RST = 0;
        for (int i = 0; i < 8; i++) begin
            WE = 1; WA = 3'(i); WD = 16'h1110 + 16'(i);
            tick();
            chk($sformatf("sweep_out%0d", i), outs[i], 16'h1110 + 16'(i));
            chk($sformatf("sweep_wack%0d", i), 16'(WACK), 16'h1);
            for (int j = i + 1; j < 8; j++)
                chk($sformatf("sweep_hold%0d_%0d", i, j), outs[j], 16'h0000);
        end
        WE = 0;
        tick();
        chk("sweep_wack_end", 16'(WACK), 16'h0);
        chk("sweep_out7_end", OUT7, 16'h1117);

        // CLR wins over a simultaneous write.
        WE = 1; WA = 3; WD = 16'hBEEF; CLR = 1;
        tick();
        WE = 0; CLR = 0;
        chk("prio_busy0", 16'(BUSY), 16'h1);
        chk("prio_wack0", 16'(WACK), 16'h0);
        chk("prio_out3_0", OUT3, 16'h1113);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("prio_busy%0d", k), 16'(BUSY), (k < 8) ? 16'h1 : 16'h0);
            chk($sformatf("prio_wack%0d", k), 16'(WACK), 16'h0);
            chk($sformatf("prio_clr%0d", k), outs[k-1], 16'h0000);
        end
        chk("prio_out3_end", OUT3, 16'h0000);

        // Preload A5A5, clear with a write and a second CLR pending.
        for (int i = 0; i < 8; i++) begin
            WE = 1; WA = 3'(i); WD = 16'hA5A5;
            tick();
        end
        WE = 0; CLR = 1;
        tick();
        CLR = 0;
        for (int k = 1; k <= 8; k++) begin
            WE = 1; WA = 5; WD = 16'h1234;
            CLR = (k == 3);
            tick();
            chk($sformatf("ord_clr%0d", k), outs[k-1], 16'h0000);
            if (k < 8)
                chk($sformatf("ord_keep%0d", k), outs[k], 16'hA5A5);
            chk($sformatf("ord_wack%0d", k), 16'(WACK), 16'h0);
        end
        WE = 0; CLR = 0;
        chk("ord_busy_end", 16'(BUSY), 16'h0);
        tick();
        chk("ord_busy_stay", 16'(BUSY), 16'h0);
        chk("ord_out5", OUT5, 16'h0000);

        // Reset in the third clear cycle aborts the sequence.
        WE = 1; WA = 6; WD = 16'h6666; tick();
        WA = 7; WD = 16'h7777; tick();
        WE = 0; CLR = 1; tick();
        CLR = 0; tick(); tick();
        chk("mid_out6_pre", OUT6, 16'h6666);
        RST = 1; tick();
        RST = 0;
        for (int i = 0; i < 8; i++) chk($sformatf("mid_out%0d", i), outs[i], 16'h0000);
        chk("mid_busy", 16'(BUSY), 16'h0);
        WE = 1; WA = 7; WD = 16'hCAFE; tick();
        WE = 0;
        chk("mid_out7", OUT7, 16'hCAFE);
        chk("mid_wack", 16'(WACK), 16'h1);
        chk_all("mid_model");

        // Random vectors against the model.
        for (int n = 0; n < 200; n++) begin
            RST = ($urandom_range(0, 63) == 0);
            CLR = ($urandom_range(0, 15) == 0);
            WE  = 1'($urandom_range(0, 1));
            WA  = 3'($urandom_range(0, 7));
            WD  = 16'($urandom);
            tick();
            chk_all($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
